e2l_skid_reg: RTL

//  EXU->LSU pipeline register with a two-entry skid buffer. Registers the EXU result packet and presents it to the LSU.

---
 rtl/core_pipe_pkg.sv | 27 ++
 rtl/pipe_skid_buf.sv | 89 ++++++++
 rtl/e2l_skid_reg.sv | 42 ++++
 3 files changed

// File: rtl/core_pipe_pkg.sv
// Shared pipeline types: EXU->LSU packet and skid-buffer state encoding.
package core_pipe_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ARGS_WIDTH = 4;
    localparam int unsigned GPRS_WIDTH = 5;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic                  reg_wr_en;
        logic [ARGS_WIDTH-1:0] reg_wr_src;
        logic [GPRS_WIDTH-1:0] gpr_wr_id;
        logic [ARGS_WIDTH-1:0] ram_byt;
        logic [DATA_WIDTH-1:0] res;
        logic                  ram_wr_en;
        logic [DATA_WIDTH-1:0] rs2_data;
        logic [ARGS_WIDTH-1:0] inst_type;
    } e2l_pkt_t;

    // State is {main_valid, skid_valid}; 2'b01 can never occur.
    localparam logic [1:0] ST_EMPTY   = 2'b00;
    localparam logic [1:0] ST_HALF    = 2'b10;
    localparam logic [1:0] ST_FULL    = 2'b11;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: main entry drives the output, skid entry
// absorbs the packet that arrives while the consumer stalls. Upstream ready
// is taken straight from the skid-valid flop.
module pipe_skid_buf
    import core_pipe_pkg::*;
#(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    T           m_q;
    T           m_d;
    T           s_q;
    T           s_d;
    logic       acc;
    logic       deq;

    assign in_ready  = ~state_q[0];
    assign out_valid = state_q[1];
    assign out_data  = m_q;
    assign acc       = in_valid & in_ready;
    assign deq       = out_valid & out_ready;

    // Next-state and payload steering; flush empties both entries.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        s_d     = s_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        m_d     = in_data;
                        state_d = ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (acc && deq) begin
                        m_d = in_data;
                    end else if (acc) begin
                        s_d     = in_data;
                        state_d = ST_FULL;
                    end else if (deq) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (deq) begin
                        m_d     = s_q;
                        state_d = ST_HALF;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Valid bits: the only reset state in the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload flops carry no reset.
    always_ff @(posedge clk) begin
        m_q <= m_d;
        s_q <= s_d;
    end

    // Skid entry can only be valid behind a valid main entry.
    a_no_illegal_state: assert property (@(posedge clk) disable iff (rst) state_q != ST_ILLEGAL);

endmodule

// File: rtl/e2l_skid_reg.sv
// EXU->LSU pipeline register built on the generic skid buffer; write enables
// are forced low whenever no packet is presented to the LSU.
module e2l_skid_reg
    import core_pipe_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_flush,
    input  logic     i_exu_valid,
    output logic     o_e2l_ready,
    input  e2l_pkt_t i_exu_pkt,
    output logic     o_e2l_valid,
    input  logic     i_lsu_ready,
    output e2l_pkt_t o_e2l_pkt
);

    e2l_pkt_t m_pkt;

    pipe_skid_buf #(
        .T (e2l_pkt_t)
    ) u_skid (
        .clk       (i_clk),
        .rst       (i_rst),
        .flush     (i_flush),
        .in_valid  (i_exu_valid),
        .in_ready  (o_e2l_ready),
        .in_data   (i_exu_pkt),
        .out_valid (o_e2l_valid),
        .out_ready (i_lsu_ready),
        .out_data  (m_pkt)
    );

    // Stale main entry must not look like a register or memory write.
    always_comb begin
        o_e2l_pkt = m_pkt;
        if (!o_e2l_valid) begin
            o_e2l_pkt.reg_wr_en = 1'b0;
            o_e2l_pkt.ram_wr_en = 1'b0;
        end
    end

endmodule
